// File: rtl/strike_detector.sv
// Drum-stick strike detector: arms on a fast gyro-Y downswing, fires on reversal,
// then blocks detection for a cooldown period. Velocity and zone are held between strikes.
module strike_detector #(
    parameter logic signed [15:0] THRESH_ON       = 16'sd4000,
    parameter logic signed [15:0] THRESH_OFF      = 16'sd1000,
    parameter logic        [23:0] COOLDOWN_CYCLES = 24'd1200000,
    parameter logic        [23:0] TIMEOUT_CYCLES  = 24'd600000,
    parameter logic signed [15:0] ZONE_EDGE       = 16'sd3000,
    parameter logic        [3:0]  VEL_SHIFT       = 4'd6
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               initialized,
    input  logic               error,
    input  logic               gyro1_valid,
    input  logic signed [15:0] gyro1_y,
    input  logic signed [15:0] quat1_z,
    output logic               strike_pulse,
    output logic [7:0]         strike_velocity,
    output logic [1:0]         strike_zone,
    output logic               armed
);

    typedef enum logic [1:0] {IDLE, ARMED, COOLDOWN} state_t;

    state_t             state;
    logic [15:0]        peak;
    logic [23:0]        timer;
    logic [23:0]        cd_cnt;
    logic signed [15:0] last_y;
    logic signed [15:0] last_z;

    logic        status_ok;
    logic        new_sample;
    logic [15:0] abs_y;
    logic [15:0] peak_max;
    logic [15:0] vel_raw;
    logic [7:0]  vel;
    logic [1:0]  zone;

    assign status_ok  = initialized && !error;
    // No upstream strobe: a change of the packet contents is the sample event.
    assign new_sample = status_ok && gyro1_valid && ({gyro1_y, quat1_z} != {last_y, last_z});
    assign armed      = (state == ARMED);

    always_comb begin
        abs_y = gyro1_y;
        if (gyro1_y == 16'sh8000)
            abs_y = 16'h7fff;
        else if (gyro1_y[15])
            abs_y = 16'(-gyro1_y);
    end

    always_comb begin
        peak_max = (abs_y > peak) ? abs_y : peak;
        vel_raw  = peak_max >> VEL_SHIFT;
        if (|vel_raw[15:8])
            vel = 8'hff;
        else if (vel_raw[7:0] == 8'd0)
            vel = 8'd1;
        else
            vel = vel_raw[7:0];
        if (quat1_z < -ZONE_EDGE)
            zone = 2'd0;
        else if (quat1_z > ZONE_EDGE)
            zone = 2'd2;
        else
            zone = 2'd1;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state           <= IDLE;
            peak            <= '0;
            timer           <= '0;
            cd_cnt          <= '0;
            last_y          <= '0;
            last_z          <= '0;
            strike_pulse    <= 1'b0;
            strike_velocity <= '0;
            strike_zone     <= '0;
        end else begin
            strike_pulse <= 1'b0;
            if (new_sample) begin
                last_y <= gyro1_y;
                last_z <= quat1_z;
            end
            // Status loss aborts a swing but lets an active cooldown run out.
            if (!status_ok) begin
                peak <= '0;
                if (state == COOLDOWN) begin
                    if (cd_cnt == COOLDOWN_CYCLES - 24'd1)
                        state <= IDLE;
                    else if (cd_cnt != '1)
                        cd_cnt <= cd_cnt + 24'd1;
                end else begin
                    state <= IDLE;
                end
            end else begin
                unique case (state)
                    IDLE: begin
                        if (new_sample && gyro1_y < -THRESH_ON) begin
                            state <= ARMED;
                            peak  <= abs_y;
                            timer <= '0;
                        end
                    end
                    ARMED: begin
                        if (new_sample) begin
                            timer <= '0;
                            if (gyro1_y > -THRESH_OFF) begin
                                state           <= COOLDOWN;
                                cd_cnt          <= '0;
                                peak            <= '0;
                                strike_pulse    <= 1'b1;
                                strike_velocity <= vel;
                                strike_zone     <= zone;
                            end else begin
                                peak <= peak_max;
                            end
                        end else if (timer == TIMEOUT_CYCLES - 24'd1) begin
                            state <= IDLE;
                            peak  <= '0;
                        end else if (timer != '1) begin
                            timer <= timer + 24'd1;
                        end
                    end
                    COOLDOWN: begin
                        if (cd_cnt == COOLDOWN_CYCLES - 24'd1)
                            state <= IDLE;
                        else if (cd_cnt != '1)
                            cd_cnt <= cd_cnt + 24'd1;
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_strike_detector.sv
// Scoreboard bench for strike_detector: stimulus queues expected strikes,
// a monitor compares every strike pulse against the queue head.
module tb_strike_detector;

    logic               clk = 1'b0;
    logic               reset;
    logic               initialized;
    logic               error;
    logic               gyro1_valid;
    logic signed [15:0] gyro1_y;
    logic signed [15:0] quat1_z;
    logic               strike_pulse;
    logic [7:0]         strike_velocity;
    logic [1:0]         strike_zone;
    logic               armed;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic [7:0] vel;
        logic [1:0] zone;
    } strike_t;

    strike_t exp_q[$];

    strike_detector #(
        .THRESH_ON       (16'sd4000),
        .THRESH_OFF      (16'sd1000),
        .COOLDOWN_CYCLES (24'd50),
        .TIMEOUT_CYCLES  (24'd40),
        .ZONE_EDGE       (16'sd3000),
        .VEL_SHIFT       (4'd6)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .initialized     (initialized),
        .error           (error),
        .gyro1_valid     (gyro1_valid),
        .gyro1_y         (gyro1_y),
        .quat1_z         (quat1_z),
        .strike_pulse    (strike_pulse),
        .strike_velocity (strike_velocity),
        .strike_zone     (strike_zone),
        .armed           (armed)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (!reset && strike_pulse) begin
            strike_t e;
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_pulse vel=%0d zone=%0d required no pulse", strike_velocity, strike_zone);
            end else begin
                e = exp_q.pop_front();
                if (strike_velocity !== e.vel || strike_zone !== e.zone) begin
                    errors++;
                    $display("FAIL strike vel=%0d zone=%0d required vel=%0d zone=%0d",
                             strike_velocity, strike_zone, e.vel, e.zone);
                end
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s got=%0d required=%0d", name, act, req);
        end
    endtask

    task automatic send(input logic signed [15:0] y, input logic signed [15:0] z);
        gyro1_y     = y;
        quat1_z     = z;
        gyro1_valid = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic expect_strike(input logic [7:0] v, input logic [1:0] zn);
        strike_t e;
        e.vel  = v;
        e.zone = zn;
        exp_q.push_back(e);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout required=finish");
        $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
        $fatal(1);
    end

    initial begin
        reset = 1'b1; initialized = 1'b0; error = 1'b0;
        gyro1_valid = 1'b0; gyro1_y = '0; quat1_z = '0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_pulse", 32'(strike_pulse), 0);
        check("reset_velocity", 32'(strike_velocity), 0);
        check("reset_zone", 32'(strike_zone), 0);
        check("reset_armed", 32'(armed), 0);
        reset = 1'b0;
        @(posedge clk); #1;

        // Not initialized: a deep downswing must be ignored.
        send(-16'sd6000, 16'sd0);
        check("uninit_armed", 32'(armed), 0);
        gyro1_valid = 1'b0;
        initialized = 1'b1;
        @(posedge clk); #1;

        // Basic swing, peak 12000 -> 187, yaw 0 -> centre.
        send(-16'sd5000, 16'sd0);
        check("swing_armed_first", 32'(armed), 1);
        send(-16'sd12000, 16'sd0);
        send(-16'sd8000, 16'sd0);
        check("swing_armed_last", 32'(armed), 1);
        expect_strike(8'd187, 2'd1);
        send(16'sd200, 16'sd0);
        check("swing_disarmed", 32'(armed), 0);

        // Swing inside cooldown is ignored.
        send(-16'sd9000, 16'sd0);
        check("cooldown_armed", 32'(armed), 0);
        send(16'sd300, 16'sd0);
        repeat (60) @(posedge clk);
        #1;

        // Same swing after cooldown; yaw exactly +ZONE_EDGE is centre.
        send(-16'sd9000, 16'sd3000);
        expect_strike(8'd140, 2'd1);
        send(16'sd300, 16'sd3000);
        repeat (60) @(posedge clk);
        #1;

        // Full-scale negative peak saturates velocity; yaw left.
        send(-16'sd32768, -16'sd4500);
        expect_strike(8'd255, 2'd0);
        send(16'sd500, -16'sd4500);
        repeat (60) @(posedge clk);
        #1;

        // Right zone just past the edge.
        send(-16'sd4500, 16'sd3001);
        expect_strike(8'd70, 2'd2);
        send(16'sd0, 16'sd3001);
        repeat (60) @(posedge clk);
        #1;

        // Timeout: armed for exactly TIMEOUT_CYCLES cycles, then idle.
        send(-16'sd6000, 16'sd0);
        repeat (39) @(posedge clk);
        #1;
        check("timeout_still_armed", 32'(armed), 1);
        @(posedge clk); #1;
        check("timeout_idle", 32'(armed), 0);
        send(16'sd500, 16'sd0);

        // Reversal arriving in the timeout cycle fires.
        send(-16'sd6000, 16'sd5);
        repeat (39) @(posedge clk);
        #1;
        check("timeout_edge_armed", 32'(armed), 1);
        expect_strike(8'd93, 2'd1);
        send(16'sd100, 16'sd10);
        repeat (60) @(posedge clk);
        #1;

        // Status drop together with reversal: no strike.
        send(-16'sd7000, 16'sd0);
        check("err_armed", 32'(armed), 1);
        error = 1'b1;
        gyro1_y = 16'sd500;
        @(posedge clk); #1;
        check("err_idle", 32'(armed), 0);
        gyro1_valid = 1'b0;
        error = 1'b0;
        @(posedge clk); #1;

        // Reset in the middle of cooldown.
        send(-16'sd5000, 16'sd0);
        expect_strike(8'd78, 2'd1);
        send(16'sd200, 16'sd0);
        repeat (10) @(posedge clk);
        #3;
        reset = 1'b1;
        #1;
        check("midreset_pulse", 32'(strike_pulse), 0);
        check("midreset_velocity", 32'(strike_velocity), 0);
        check("midreset_zone", 32'(strike_zone), 0);
        check("midreset_armed", 32'(armed), 0);
        #2;
        reset = 1'b0;
        @(posedge clk); #1;
        send(-16'sd12000, 16'sd4000);
        check("postreset_armed", 32'(armed), 1);
        expect_strike(8'd187, 2'd2);
        send(16'sd200, 16'sd4000);
        repeat (3) @(posedge clk);
        #1;
        check("hold_velocity", 32'(strike_velocity), 187);
        check("hold_zone", 32'(strike_zone), 2);

        repeat (5) @(posedge clk);
        #1;
        check("missing_pulses", 32'(exp_q.size()), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
